// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding,
// default operand width and the iteration-counter sizing helper.
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Bits needed to hold the iteration count WIDTH down to 1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_divider_full_subtractor.sv
// One-bit full subtractor cell (a - b - borrow_in), the building block of
// the divider's trial-subtraction ripple chain.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    assign diff       = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock using a
// WIDTH+1-bit ripple subtractor. start/busy/done handshake:
//   start is sampled only while busy=0 (IDLE or the FINISH/done cycle);
//   busy is high from the accepting edge until the edge that raises done;
//   done is a one-cycle pulse, and quotient/remainder/div_by_zero are held
//   from that edge until the next accepted start or rst.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;          // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] d_q, d_d;          // latched divisor
    logic [WIDTH:0]   r_q, r_d;          // partial remainder
    logic [CW-1:0]    cnt_q, cnt_d;      // iterations left
    logic             zero_q, zero_d;    // operation in flight has divisor 0
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_b;
    logic [WIDTH:0]   trial_t;
    logic [WIDTH+1:0] borrow;
    logic             trial_borrow;
    logic             unused_r_msb;

    // The partial remainder stays below the divisor, so its top bit only
    // exists to keep the trial subtraction from overflowing.
    assign unused_r_msb = r_q[WIDTH];

    assign trial_a   = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign trial_b   = {1'b0, d_q};
    assign borrow[0] = 1'b0;

    // Ripple chain of full subtractors computing trial_a - trial_b.
    for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_sub
        full_subtractor u_fs (
            .a          (trial_a[gi]),
            .b          (trial_b[gi]),
            .borrow_in  (borrow[gi]),
            .diff       (trial_t[gi]),
            .borrow_out (borrow[gi+1])
        );
    end

    assign trial_borrow = borrow[WIDTH+1];

    // Next-state, datapath and result computation.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE, FINISH: begin
                state_d = IDLE;
                if (start) begin
                    q_d     = dividend;
                    d_d     = divisor;
                    r_d     = '0;
                    cnt_d   = CW'(WIDTH);
                    zero_d  = (divisor == '0);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (zero_q) begin
                    // Divide by zero spends a single busy cycle, then reports
                    // all-ones quotient and the untouched dividend.
                    quot_d  = '1;
                    rem_d   = q_q;
                    dbz_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    if (!trial_borrow) begin
                        r_d = trial_t;
                        q_d = {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        r_d = trial_a;
                        q_d = {q_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        quot_d  = q_d;
                        rem_d   = r_d[WIDTH-1:0];
                        dbz_d   = 1'b0;
                        state_d = FINISH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == FINISH);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider at WIDTH=3: table vectors, handshake corner cases
// and an exhaustive back-to-back sweep, with a done-driven scoreboard.
module tb_seq_divider;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  // Expected results packed as {div_by_zero, quotient, remainder}.
  logic [2*W:0] exp_q[$];
  logic [2*W:0] mon_e;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vecs[8];

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    return {1'b0, W'(a / b), W'(a % b)};
  endfunction

  // Drive one start (accepted at the next edge) and record its expected result.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W:0] e);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = W'($urandom_range(0, (1 << W) - 1));
    divisor  = W'($urandom_range(0, (1 << W) - 1));
    check("busy_after_start", busy, 1);
    check("done_after_start", done, 0);
  endtask

  // Wait (bounded) for done; n counts edges after the accepting edge.
  task automatic wait_done(input int expect_n, input string name);
    int n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_done"}, done, 1);
    check({name, "_latency"}, n, expect_n);
    check({name, "_busy_low"}, busy, 0);
  endtask

  // Scoreboard: every done pulse pops and compares one expectation.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("quotient", quotient, mon_e[2*W-1:W]);
        check("remainder", remainder, mon_e[W-1:0]);
        check("div_by_zero", div_by_zero, mon_e[2*W]);
      end
    end
  end

  initial begin
    vecs[0] = '{a: 3'd7, b: 3'd2, q: 3'd3, r: 3'd1, z: 1'b0, lat: 3};
    vecs[1] = '{a: 3'd2, b: 3'd5, q: 3'd0, r: 3'd2, z: 1'b0, lat: 3};
    vecs[2] = '{a: 3'd6, b: 3'd3, q: 3'd2, r: 3'd0, z: 1'b0, lat: 3};
    vecs[3] = '{a: 3'd5, b: 3'd0, q: 3'd7, r: 3'd5, z: 1'b1, lat: 1};
    vecs[4] = '{a: 3'd3, b: 3'd4, q: 3'd0, r: 3'd3, z: 1'b0, lat: 3};
    vecs[5] = '{a: 3'd7, b: 3'd7, q: 3'd1, r: 3'd0, z: 1'b0, lat: 3};
    vecs[6] = '{a: 3'd0, b: 3'd3, q: 3'd0, r: 3'd0, z: 1'b0, lat: 3};
    vecs[7] = '{a: 3'd6, b: 3'd4, q: 3'd1, r: 3'd2, z: 1'b0, lat: 3};

    // Reset, with start held high to show rst wins.
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 3'd7;
    divisor  = 3'd2;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", busy, 0);

    // Table vectors, each from IDLE.
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, {vecs[i].z, vecs[i].q, vecs[i].r});
      wait_done(vecs[i].lat, "vec");
      @(posedge clk); #1;
      check("vec_done_pulse", done, 0);
      check("vec_idle_busy", busy, 0);
      check("vec_hold_quotient", quotient, vecs[i].q);
      check("vec_hold_dbz", div_by_zero, vecs[i].z);
    end

    // start during RUN is ignored; start during FINISH is accepted.
    start_op(3'd7, 3'd1, {1'b0, 3'd7, 3'd0});
    dividend = 3'd4;
    divisor  = 3'd2;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ignored_start_busy", busy, 1);
    wait_done(W - 1, "ignore");
    start_op(3'd4, 3'd2, {1'b0, 3'd2, 3'd0});
    wait_done(W, "b2b");
    @(posedge clk); #1;

    // Reset two cycles into 7/3: aborts with no done pulse.
    dividend = 3'd7;
    divisor  = 3'd3;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk);
    rst = 1'b1;
    #1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_done", done, 0);
    start_op(3'd7, 3'd3, {1'b0, 3'd2, 3'd1});
    wait_done(W, "after_abort");
    @(posedge clk); #1;

    // Exhaustive sweep, back-to-back through the FINISH cycle.
    for (int i = 0; i < 64; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = i[5:3];
      b = i[2:0];
      start_op(a, b, model(a, b));
      wait_done((b == '0) ? 1 : W, "exh");
    end
    @(posedge clk); #1;
    check("exh_idle_busy", busy, 0);
    check("exh_idle_done", done, 0);

    repeat (2) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
